mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the VeriRISC control strobes: serves `mem_rd` / `mem_wr` issued by the CPU controller against an internal word array.
- Adds programmable wait states and a one-cycle `ready` pulse.
- Holds read data stable while the controller keeps `mem_rd` asserted across several of its states.
- Sits between the controller/datapath address mux and the accumulator/IR load path.

Parameters:
- AWIDTH, 5: address width; the array holds 2**AWIDTH words.
- DWIDTH, 8: data word width.
- WAIT_CYCLES, 1: wait states inserted before completion; range 0..15.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- mem_rd  input  1  read strobe from controller (level)
- mem_wr  input  1  write strobe from controller (level)
- addr  input  AWIDTH  word address
- data_in  input  DWIDTH  write data (accumulator)
- data_out  output  DWIDTH  registered read data
- ready  output  1  one-cycle completion pulse, read or write
- busy  output  1  high while an access is in flight
- err  output  1  sticky protocol error

Behaviour:
- Reset (asynchronous, reset=0) drives all outputs to 0 and the state to IDLE. Array contents are not reset.
- An in-flight write is aborted by reset and not committed.
- Edge detection: rd_q and wr_q register the previous cycle's strobes (both reset to 0).
  - start_rd = mem_rd & ~rd_q.
  - start_wr = mem_wr & ~wr_q.
  - A level held high does not retrigger.
- FSM states: IDLE, WAIT, DONE_RD, DONE_WR.
- IDLE:
  - start_rd alone: latch addr, load wcnt = WAIT_CYCLES, busy=1. Go to WAIT if WAIT_CYCLES>0, else DONE_RD.
  - start_wr alone: latch addr and data_in, same wcnt handling. Go to WAIT or DONE_WR.
  - start_rd and start_wr in the same cycle: no access, err<=1, stay IDLE.
- WAIT:
  - wcnt decrements each cycle.
  - When wcnt==1, go to DONE_RD or DONE_WR according to the latched op.
  - Strobe changes during WAIT are ignored; the captured access always completes.
  - A new rising edge during WAIT sets err and is dropped.
- DONE_RD: data_out <= mem[latched addr], ready=1 for this cycle, busy=0, next state IDLE.
- DONE_WR: mem[latched addr] <= latched data, ready=1, busy=0, next state IDLE. data_out is unchanged.
- Latency: edge sampled at cycle N gives ready=1 at cycle N+1+WAIT_CYCLES.
- data_out holds the last completed read until the next read completes.
- err clears only on reset.
- Edge detection and start conditions are evaluated only in IDLE, but rd_q/wr_q update every cycle.
- Address wrap: addr is exactly AWIDTH bits, so there is no out-of-range case.

Optional Feature:
- Macro: MEM_RESP_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed on write commit.
  - DONE_RD recomputes parity.
  - On mismatch, an extra 1-bit output `parity_err` pulses with ready, and err is also set.
  - Adds a 2-bit `inject` input; bit0 flips the stored parity on the next write, for test.
- Undefined: no parity storage and no parity_err / inject ports.

Decomposition:
- Shared package (typedefs): add mem_state_t enum {IDLE, WAIT, DONE_RD, DONE_WR} and the constant MEM_MAX_WAIT=15.
- Sub-module mem_wait_counter:
  - Loadable 4-bit down-counter with `load`, `value`, `expire` outputs.
  - Instantiated once; the FSM and array stay in mem_responder.

Test Plan:
- Reset then write: WAIT_CYCLES=1; mem_wr rises with addr=5'h03, data_in=8'hA5 at cycle 0 -> ready=1 at cycle 2, busy=1 in cycles 1..1. A later read of 5'h03 returns data_out=8'hA5 with ready at cycle+2.
- WAIT_CYCLES=0 back-to-back: read at cycle 0, drop mem_rd at cycle 1, raise it again at cycle 2 -> ready at cycles 1 and 3, data_out stable between them.
- Held strobe: mem_rd high for 4 cycles at addr 5'h1F -> exactly one ready pulse; data_out = mem[31] throughout after completion.
- Simultaneous rising mem_rd and mem_wr -> no ready, busy=0, err=1 and remaining 1 until reset; array unchanged.
- Reset mid-write: WAIT_CYCLES=3; write 8'h5C to 5'h07, assert reset at cycle 2 -> all outputs 0 immediately, and a subsequent read of 5'h07 returns the prior value.
- MEM_RESP_PARITY_EN: write with inject[0]=1, then read the same address -> parity_err=1 in the ready cycle and err=1. A normal write/read pair -> parity_err=0.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder slice.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DONE_RD = 2'd2,
    DONE_WR = 2'd3
  } mem_state_t;

  localparam int MEM_MAX_WAIT = 15;
  localparam int MEM_WCNT_W   = 4;

  // Clamp a requested wait-state count into what the 4-bit counter can hold.
  function automatic logic [MEM_WCNT_W-1:0] wait_load(input int cycles);
    logic [MEM_WCNT_W-1:0] v;
    if (cycles > MEM_MAX_WAIT) begin
      v = MEM_WCNT_W'(MEM_MAX_WAIT);
    end else if (cycles < 0) begin
      v = '0;
    end else begin
      v = MEM_WCNT_W'(cycles);
    end
    return v;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable 4-bit down-counter that times the wait states of one access.
// Latency: load takes effect on the next edge; expire is combinational from the count.
// Backpressure: none; load wins over decrement, and the count saturates at zero.
module mem_wait_counter
  import mem_responder_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [MEM_WCNT_W-1:0] load_val,
  input  logic                  dec,
  output logic [MEM_WCNT_W-1:0] value,
  output logic                  expire
);

  localparam logic [MEM_WCNT_W-1:0] ONE = MEM_WCNT_W'(1);

  logic [MEM_WCNT_W-1:0] cnt_q;
  logic [MEM_WCNT_W-1:0] cnt_d;

  // Load has priority; decrement never wraps below zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value  = cnt_q;
  assign expire = (cnt_q == ONE);

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the controller's mem_rd/mem_wr level strobes, with optional parity (MEM_RESP_PARITY_EN).
// Latency: a strobe edge sampled at cycle N gives a one-cycle ready at cycle N+1+WAIT_CYCLES.
// Backpressure: none; edges arriving while an access is in flight are dropped and flagged on sticky err.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int AWIDTH      = 5,
  parameter int DWIDTH      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] data_in,
`ifdef MEM_RESP_PARITY_EN
  input  logic [1:0]        inject,
  output logic              parity_err,
`endif
  output logic [DWIDTH-1:0] data_out,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam logic [MEM_WCNT_W-1:0] WAIT_LD = wait_load(WAIT_CYCLES);
  localparam bit                    NO_WAIT = (WAIT_LD == '0);

  mem_state_t        state_q, state_d;
  logic              rd_q, wr_q;
  logic              op_wr_q, op_wr_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdat_q, wdat_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [DWIDTH-1:0] data_out_q, data_out_d;

  logic              start_rd, start_wr;
  logic              complete;
  logic              wcnt_load, wcnt_dec, wcnt_expire;
  logic [MEM_WCNT_W-1:0] wcnt_unused;

  // Array port: address/data come straight from the inputs when an access
  // completes without wait states, otherwise from the latched request.
  logic              mem_we;
  logic [AWIDTH-1:0] acc_addr;
  logic [DWIDTH-1:0] acc_wdat;
  logic [DWIDTH-1:0] mem_q [2**AWIDTH];

`ifdef MEM_RESP_PARITY_EN
  logic              mem_par_q [2**AWIDTH];
  logic              inj_q, inj_d, acc_inj;
  logic              parity_err_q, parity_err_d;
  logic              inject_unused;

  // inject[1] has no function yet
  assign inject_unused = inject[1];
`endif

  mem_wait_counter u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (wcnt_load),
    .load_val (WAIT_LD),
    .dec      (wcnt_dec),
    .value    (wcnt_unused),
    .expire   (wcnt_expire)
  );

  // Sequencer next state: accept edges in IDLE, time the wait, complete into DONE_*.
  // Read data, ready and the array write all happen on the edge entering DONE_*,
  // so data_out is already valid in the cycle ready is high.
  always_comb begin
    start_rd   = mem_rd & ~rd_q;
    start_wr   = mem_wr & ~wr_q;
    state_d    = state_q;
    op_wr_d    = op_wr_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    ready_d    = 1'b0;
    busy_d     = busy_q;
    err_d      = err_q;
    data_out_d = data_out_q;
    wcnt_load  = 1'b0;
    wcnt_dec   = 1'b0;
    complete   = 1'b0;
    mem_we     = 1'b0;
    acc_addr   = addr_q;
    acc_wdat   = wdat_q;
`ifdef MEM_RESP_PARITY_EN
    inj_d        = inj_q;
    acc_inj      = inj_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        acc_addr = addr;
        acc_wdat = data_in;
`ifdef MEM_RESP_PARITY_EN
        acc_inj  = inject[0];
`endif
        if (start_rd && start_wr) begin
          err_d = 1'b1;
        end else if (start_rd || start_wr) begin
          op_wr_d   = start_wr;
          addr_d    = addr;
          wdat_d    = start_wr ? data_in : wdat_q;
`ifdef MEM_RESP_PARITY_EN
          inj_d     = start_wr ? inject[0] : inj_q;
`endif
          wcnt_load = 1'b1;
          if (NO_WAIT) begin
            complete = 1'b1;
          end else begin
            state_d = WAIT;
            busy_d  = 1'b1;
          end
        end
      end
      WAIT: begin
        wcnt_dec = 1'b1;
        if (start_rd || start_wr) begin
          err_d = 1'b1;
        end
        if (wcnt_expire) begin
          complete = 1'b1;
        end
      end
      default: begin
        // DONE_RD / DONE_WR last exactly one cycle
        state_d = IDLE;
      end
    endcase

    if (complete) begin
      ready_d = 1'b1;
      busy_d  = 1'b0;
      if (op_wr_d) begin
        state_d = DONE_WR;
        mem_we  = 1'b1;
      end else begin
        state_d    = DONE_RD;
        data_out_d = mem_q[acc_addr];
`ifdef MEM_RESP_PARITY_EN
        parity_err_d = (^mem_q[acc_addr]) != mem_par_q[acc_addr];
        if (parity_err_d) begin
          err_d = 1'b1;
        end
`endif
      end
    end
  end

  // Sequencer state and registered outputs; edge history updates every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdat_q     <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= '0;
`ifdef MEM_RESP_PARITY_EN
      inj_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rd_q       <= mem_rd;
      wr_q       <= mem_wr;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      data_out_q <= data_out_d;
`ifdef MEM_RESP_PARITY_EN
      inj_q        <= inj_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Word array (not reset); a write only lands on its completion edge
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[acc_addr] <= acc_wdat;
`ifdef MEM_RESP_PARITY_EN
      mem_par_q[acc_addr] <= (^acc_wdat) ^ acc_inj;
`endif
    end
  end

  assign data_out = data_out_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign err      = err_q;
`ifdef MEM_RESP_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances with WAIT_CYCLES 1, 0 and 3, each with its own stimulus.
// Latency: expected ready cycle and read data are queued when a strobe is raised and compared on ready.
// Backpressure: n/a; every wait on ready is bounded by a cycle budget.
module tb_mem_responder;

  localparam int AW  = 5;
  localparam int DW  = 8;
  localparam int N   = 3;
  localparam int WC0 = 1;
  localparam int WC1 = 0;
  localparam int WC2 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]         rstn, rd, wr, rdy, bsy, er;
  logic [N-1:0][AW-1:0] adr;
  logic [N-1:0][DW-1:0] din, dout;
`ifdef MEM_RESP_PARITY_EN
  logic [N-1:0][1:0]    inj;
  logic [N-1:0]         perr;
`endif

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(
      .AWIDTH      (AW),
      .DWIDTH      (DW),
      .WAIT_CYCLES ((g == 0) ? WC0 : ((g == 1) ? WC1 : WC2))
    ) u_dut (
      .clk        (clk),
      .reset      (rstn[g]),
      .mem_rd     (rd[g]),
      .mem_wr     (wr[g]),
      .addr       (adr[g]),
      .data_in    (din[g]),
`ifdef MEM_RESP_PARITY_EN
      .inject     (inj[g]),
      .parity_err (perr[g]),
`endif
      .data_out   (dout[g]),
      .ready      (rdy[g]),
      .busy       (bsy[g]),
      .err        (er[g])
    );
  end

  typedef struct {
    int          k;
    bit          is_rd;
    logic [DW-1:0] dat;
    int          due;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [N][2**AW];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc_of(input int k);
    return (k == 0) ? WC0 : ((k == 1) ? WC1 : WC2);
  endfunction

  // Raise a strobe (call just after a negedge) and queue what the DUT must return.
  task automatic start_access(input int k, input bit is_rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    adr[k] = a;
    din[k] = d;
    if (is_rd) rd[k] = 1'b1;
    else       wr[k] = 1'b1;
    e.k     = k;
    e.is_rd = is_rd;
    e.dat   = is_rd ? model[k][a] : d;
    e.due   = cyc + 1 + wc_of(k);
    if (!is_rd) model[k][a] = d;
    sb.push_back(e);
  endtask

  task automatic wait_ready(input int k, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (rdy[k] === 1'b1) got = 1'b1;
    end
  endtask

  // Preload a word; leaves the DUT idle with strobes low
  task automatic write_setup(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got;
    adr[k] = a;
    din[k] = d;
    wr[k]  = 1'b1;
    wait_ready(k, 32, got);
    wr[k] = 1'b0;
    model[k][a] = d;
    n_chk++;
    if (!got) $display("FAIL setup_write dut%0d addr %h: no ready within 32 cycles", k, a);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = '0; rd = '0; wr = '0; adr = '0; din = '0;
`ifdef MEM_RESP_PARITY_EN
    inj = '0;
`endif
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if ({dout[k], rdy[k], bsy[k], er[k]} !== '0)
        $display("FAIL reset_outputs dut%0d: dout=%h ready=%b busy=%b err=%b, expected all zero",
                 k, dout[k], rdy[k], bsy[k], er[k]);
      else n_pass++;
    end
    rstn = '1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    exp_t e;
    bit   got;
    start_access(0, 1'b0, 5'h03, 8'hA5);
    @(negedge clk);
    n_chk++;
    if (bsy[0] !== 1'b1 || rdy[0] !== 1'b0)
      $display("FAIL wr_wait_state: busy=%b ready=%b, expected busy=1 ready=0", bsy[0], rdy[0]);
    else n_pass++;
    @(negedge clk);
    e = sb.pop_front();
    n_chk++;
    if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || cyc != e.due)
      $display("FAIL wr_ready: ready=%b busy=%b cycle=%0d, expected ready=1 busy=0 cycle=%0d",
               rdy[0], bsy[0], cyc, e.due);
    else n_pass++;
    wr[0] = 1'b0;
    @(negedge clk);
    start_access(0, 1'b1, 5'h03, 8'h00);
    wait_ready(0, 10, got);
    e = sb.pop_front();
    n_chk++;
    if (!got || cyc != e.due || dout[0] !== e.dat)
      $display("FAIL rd_after_wr: got=%b cycle=%0d data=%h, expected cycle=%0d data=%h",
               got, cyc, dout[0], e.due, e.dat);
    else n_pass++;
    rd[0] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (rdy[0] !== 1'b0 || dout[0] !== e.dat)
      $display("FAIL ready_one_cycle: ready=%b data=%h, expected ready=0 data=%h", rdy[0], dout[0], e.dat);
    else n_pass++;
  endtask

  task automatic test_held_strobe();
    exp_t e;
    int   pulses;
    int   at;
    pulses = 0;
    at     = -1;
    write_setup(0, 5'h1F, 8'h96);
    start_access(0, 1'b1, 5'h1F, 8'h00);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rdy[0] === 1'b1) begin
        pulses++;
        at = cyc;
      end
      if (i == 3) rd[0] = 1'b0;
    end
    e = sb.pop_front();
    n_chk++;
    if (pulses != 1 || at != e.due)
      $display("FAIL held_single_ready: pulses=%0d at cycle %0d, expected 1 at cycle %0d", pulses, at, e.due);
    else n_pass++;
    n_chk++;
    if (dout[0] !== e.dat || er[0] !== 1'b0)
      $display("FAIL held_data_hold: data=%h err=%b, expected data=%h err=0", dout[0], er[0], e.dat);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   got;
    write_setup(1, 5'h0A, 8'h3C);
    write_setup(1, 5'h0B, 8'hC3);
    start_access(1, 1'b1, 5'h0A, 8'h00);
    @(negedge clk);
    e = sb.pop_front();
    n_chk++;
    if (rdy[1] !== 1'b1 || dout[1] !== e.dat || cyc != e.due)
      $display("FAIL b2b_first: ready=%b data=%h cycle=%0d, expected ready=1 data=%h cycle=%0d",
               rdy[1], dout[1], cyc, e.dat, e.due);
    else n_pass++;
    rd[1] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (rdy[1] !== 1'b0 || dout[1] !== 8'h3C)
      $display("FAIL b2b_gap: ready=%b data=%h, expected ready=0 data=3c", rdy[1], dout[1]);
    else n_pass++;
    start_access(1, 1'b1, 5'h0A, 8'h00);
    @(negedge clk);
    e = sb.pop_front();
    n_chk++;
    if (rdy[1] !== 1'b1 || dout[1] !== e.dat || cyc != e.due)
      $display("FAIL b2b_second: ready=%b data=%h cycle=%0d, expected ready=1 data=%h cycle=%0d",
               rdy[1], dout[1], cyc, e.dat, e.due);
    else n_pass++;
    rd[1] = 1'b0;
    @(negedge clk);
    start_access(1, 1'b1, 5'h0B, 8'h00);
    wait_ready(1, 5, got);
    e = sb.pop_front();
    n_chk++;
    if (!got || dout[1] !== e.dat || cyc != e.due)
      $display("FAIL b2b_new_addr: got=%b data=%h cycle=%0d, expected data=%h cycle=%0d",
               got, dout[1], cyc, e.dat, e.due);
    else n_pass++;
    rd[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    exp_t e;
    bit   got;
    bit   saw_rdy;
    bit   saw_bsy;
    saw_rdy = 1'b0;
    saw_bsy = 1'b0;
    write_setup(2, 5'h05, 8'h11);
    adr[2] = 5'h05;
    din[2] = 8'hEE;
    rd[2]  = 1'b1;
    wr[2]  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rdy[2] !== 1'b0) saw_rdy = 1'b1;
      if (bsy[2] !== 1'b0) saw_bsy = 1'b1;
    end
    n_chk++;
    if (saw_rdy || saw_bsy)
      $display("FAIL simul_no_access: saw ready=%b busy=%b, expected neither", saw_rdy, saw_bsy);
    else n_pass++;
    n_chk++;
    if (er[2] !== 1'b1) $display("FAIL simul_err: err=%b, expected 1", er[2]);
    else n_pass++;
    rd[2] = 1'b0;
    wr[2] = 1'b0;
    @(negedge clk);
    start_access(2, 1'b1, 5'h05, 8'h00);
    wait_ready(2, 10, got);
    e = sb.pop_front();
    n_chk++;
    if (!got || dout[2] !== e.dat || cyc != e.due)
      $display("FAIL simul_array_unchanged: got=%b data=%h cycle=%0d, expected data=%h cycle=%0d",
               got, dout[2], cyc, e.dat, e.due);
    else n_pass++;
    n_chk++;
    if (er[2] !== 1'b1) $display("FAIL err_sticky: err=%b, expected 1", er[2]);
    else n_pass++;
    rd[2] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    exp_t e;
    bit   got;
    write_setup(2, 5'h07, 8'h21);
    adr[2] = 5'h07;
    din[2] = 8'h5C;
    wr[2]  = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (bsy[2] !== 1'b1) $display("FAIL rst_inflight: busy=%b, expected 1", bsy[2]);
    else n_pass++;
    rstn[2] = 1'b0;
    #1;
    n_chk++;
    if ({dout[2], rdy[2], bsy[2], er[2]} !== '0)
      $display("FAIL rst_async_clear: dout=%h ready=%b busy=%b err=%b, expected all zero",
               dout[2], rdy[2], bsy[2], er[2]);
    else n_pass++;
    wr[2] = 1'b0;
    @(negedge clk);
    rstn[2] = 1'b1;
    @(negedge clk);
    // Read the word back; a write edge raised mid-wait must be flagged and dropped
    start_access(2, 1'b1, 5'h07, 8'h00);
    @(negedge clk);
    rd[2] = 1'b0;
    wr[2] = 1'b1;
    wait_ready(2, 10, got);
    e = sb.pop_front();
    n_chk++;
    if (!got || dout[2] !== e.dat || cyc != e.due)
      $display("FAIL rst_write_aborted: got=%b data=%h cycle=%0d, expected data=%h cycle=%0d",
               got, dout[2], cyc, e.dat, e.due);
    else n_pass++;
    n_chk++;
    if (er[2] !== 1'b1) $display("FAIL wait_edge_err: err=%b, expected 1", er[2]);
    else n_pass++;
    wr[2] = 1'b0;
    @(negedge clk);
    start_access(2, 1'b1, 5'h07, 8'h00);
    wait_ready(2, 10, got);
    e = sb.pop_front();
    n_chk++;
    if (!got || dout[2] !== e.dat)
      $display("FAIL wait_edge_dropped: got=%b data=%h, expected data=%h", got, dout[2], e.dat);
    else n_pass++;
    rd[2] = 1'b0;
    @(negedge clk);
  endtask

`ifdef MEM_RESP_PARITY_EN
  task automatic test_parity();
    exp_t e;
    bit   got;
    write_setup(0, 5'h0C, 8'h5A);
    start_access(0, 1'b1, 5'h0C, 8'h00);
    wait_ready(0, 10, got);
    e = sb.pop_front();
    n_chk++;
    if (!got || perr[0] !== 1'b0 || er[0] !== 1'b0 || dout[0] !== e.dat)
      $display("FAIL parity_clean: got=%b parity_err=%b err=%b data=%h, expected 0 0 %h",
               got, perr[0], er[0], dout[0], e.dat);
    else n_pass++;
    rd[0] = 1'b0;
    @(negedge clk);
    inj[0] = 2'b01;
    write_setup(0, 5'h0D, 8'h77);
    inj[0] = 2'b00;
    start_access(0, 1'b1, 5'h0D, 8'h00);
    wait_ready(0, 10, got);
    e = sb.pop_front();
    n_chk++;
    if (!got || perr[0] !== 1'b1 || er[0] !== 1'b1 || dout[0] !== e.dat)
      $display("FAIL parity_inject: got=%b parity_err=%b err=%b data=%h, expected 1 1 %h",
               got, perr[0], er[0], dout[0], e.dat);
    else n_pass++;
    rd[0] = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_read();
    test_held_strobe();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid_write();
`ifdef MEM_RESP_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
